// File: rtl/button_event_resp.sv
// button_event_resp: five push-buttons -> synchronizer -> debouncer -> press
// events, with a small register window (LEVEL, EVENT W1C, COUNT, MASK).
// Optional feature macro BTN_IRQ_EN: builds the MASK register and a registered
// irq = |(EVENT & MASK). Without it MASK reads 0 and irq is tied low.
module button_event_resp #(
  parameter int DEB_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  btn,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  // Counter only has to reach DEB_CYCLES-1; the flip happens on that edge.
  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    REG_LEVEL = 2'd0,
    REG_EVENT = 2'd1,
    REG_COUNT = 2'd2,
    REG_MASK  = 2'd3
  } reg_sel_e;

  logic [4:0]       sync1_q, sync2_q;
  logic [CNT_W-1:0] deb_cnt_q [5];
  logic [CNT_W-1:0] deb_cnt_d [5];
  logic [4:0]       level_q, level_d;
  logic [4:0]       press;
  logic [2:0]       n_press;
  logic [4:0]       flags_q, flags_d;
  logic [15:0]      count_q, count_d;
  logic [4:0]       mask_rd;
  reg_sel_e         sel;
  logic             wr_event, wr_count;
  logic             unused_bits;

  assign sel      = reg_sel_e'(addr[3:2]);
  assign wr_event = we && (sel == REG_EVENT);
  assign wr_count = we && (sel == REG_COUNT);

  // Only addr[3:2] and wdata[4:0] carry meaning for this block.
  assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:5]};

  // Two-flop synchronizer: nothing downstream ever sees the raw pins.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values, so
    // sync2_q gets the old sync1_q no matter how the statements are ordered.
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // Debounce next state: a level flips once its input has disagreed for DEB_CYCLES cycles.
  always_comb begin
    // NOTE: defaults first, so no path through the loop leaves an output
    // unassigned and no latch is inferred.
    level_d = level_q;
    for (int i = 0; i < 5; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (deb_cnt_q[i] == CNT_LAST) begin
          level_d[i] = ~level_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // A press is the cycle in which a debounced level is about to rise.
  assign press = level_d & ~level_q;

  // Number of simultaneous presses (0..5) feeding COUNT.
  always_comb begin
    n_press = '0;
    for (int i = 0; i < 5; i++) begin
      n_press = n_press + {2'b00, press[i]};
    end
  end

  // Flag/counter next state: new presses beat a same-cycle W1C, a COUNT write restarts from this cycle's presses.
  always_comb begin
    flags_d = (flags_q & ~(wr_event ? wdata[4:0] : 5'b0)) | press;
    count_d = wr_count ? {13'b0, n_press} : count_q + {13'b0, n_press};
  end

  // Debounce counters, debounced levels, event flags and press counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the counter array is only five small registers, not a RAM; it is
      // cleared so a partial count never survives reset into a spurious press.
      for (int i = 0; i < 5; i++) deb_cnt_q[i] <= '0;
      level_q <= '0;
      flags_q <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < 5; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      level_q <= level_d;
      flags_q <= flags_d;
      count_q <= count_d;
    end
  end

`ifdef BTN_IRQ_EN
  logic [4:0] mask_q;
  logic       irq_q;
  logic       wr_mask;

  assign wr_mask = we && (sel == REG_MASK);

  // Mask register and interrupt, one cycle behind any flag or mask change.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_mask) mask_q <= wdata[4:0];
      irq_q <= |(flags_q & mask_q);
    end
  end

  assign mask_rd = mask_q;
  assign irq     = irq_q;
`else
  assign mask_rd = '0;
  assign irq     = 1'b0;
`endif

  // Zero-latency read mux; everything reads 0 while reset is held.
  always_comb begin
    rdata = '0;
    if (!rst) begin
      case (sel)
        REG_LEVEL: rdata = {27'b0, level_q};
        REG_EVENT: rdata = {27'b0, flags_q};
        REG_COUNT: rdata = {16'b0, count_q};
        REG_MASK:  rdata = {27'b0, mask_rd};
        default:   rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_resp.sv
// tb_button_event_resp: directed scenarios plus a randomized phase, all checked
// against a history-window reference model. Honours BTN_IRQ_EN like the design.
module tb_button_event_resp;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  btn;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  button_event_resp #(.DEB_CYCLES(DEB)) dut (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  // ---------------- reference model ----------------
  logic [4:0]  m_level, m_flags, m_mask;
  logic [15:0] m_count;
  logic        m_irq;
  logic [4:0]  pipe[$];    // synchronizer contents: front is next compared value
  logic [4:0]  s_hist[$];  // synchronized value compared at each edge since reset
  int          since[5];   // first history index still relevant to each button

  function automatic logic [31:0] model_read(input logic [1:0] sel);
    if (rst) return 32'h0;
    case (sel)
      2'd0:    return {27'b0, m_level};
      2'd1:    return {27'b0, m_flags};
      2'd2:    return {16'b0, m_count};
      default: return {27'b0, m_mask};
    endcase
  endfunction

  function automatic void model_step();
    logic [4:0] s, nxt, press, clr;
    logic       irq_nxt;
    int         n;
    bit         all_diff;
    irq_nxt = 1'b0;
`ifdef BTN_IRQ_EN
    irq_nxt = |(m_flags & m_mask);
`endif
    if (rst) begin
      m_level = '0; m_flags = '0; m_count = '0; m_mask = '0; m_irq = 1'b0;
      pipe = '{5'd0, 5'd0};
      s_hist.delete();
      for (int i = 0; i < 5; i++) since[i] = 0;
      return;
    end
    s = pipe.pop_front();
    pipe.push_back(btn);
    s_hist.push_back(s);
    n = s_hist.size();
    nxt = m_level;
    for (int i = 0; i < 5; i++) begin
      if (n - since[i] >= DEB) begin
        all_diff = 1'b1;
        for (int j = n - DEB; j < n; j++)
          if (s_hist[j][i] == m_level[i]) all_diff = 1'b0;
        if (all_diff) begin
          nxt[i]   = ~m_level[i];
          since[i] = n;
        end
      end
    end
    press = nxt & ~m_level;
    clr   = (we && addr[3:2] == 2'd1) ? wdata[4:0] : 5'd0;
    m_flags = (m_flags & ~clr) | press;
    if (we && addr[3:2] == 2'd2) m_count = 16'($countones(press));
    else                         m_count = m_count + 16'($countones(press));
`ifdef BTN_IRQ_EN
    if (we && addr[3:2] == 2'd3) m_mask = wdata[4:0];
`endif
    m_irq   = irq_nxt;
    m_level = nxt;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: DUT and model advance on the same edge; returns at the next negedge.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    for (int a = 0; a < 4; a++) begin
      addr = 32'(a) << 2;
      #1 check($sformatf("%s_reg%0d", tag, a), rdata, model_read(2'(a)));
    end
    check({tag, "_irq"}, {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic bus_write(input int a, input logic [31:0] d);
    addr  = 32'(a) << 2;
    wdata = d;
    we    = 1'b1;
    step();
    we    = 1'b0;
    wdata = '0;
  endtask

  task automatic read_chk(input string tag, input int a, input logic [31:0] exp);
    addr = 32'(a) << 2;
    #1 check(tag, rdata, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; btn = '0; addr = '0; we = 1'b0; wdata = '0;
    m_level = '0; m_flags = '0; m_count = '0; m_mask = '0; m_irq = 1'b0;
    pipe = '{5'd0, 5'd0};
    for (int i = 0; i < 5; i++) since[i] = 0;

    // Reset state, during and after reset.
    repeat (3) step();
    check_all("in_reset");
    rst = 1'b0;
    step();
    check_all("post_reset");

    // Single held press: level rises exactly 6 cycles after the input.
    btn = 5'b00001;
    for (int c = 1; c <= 10; c++) begin
      step();
      addr = 32'h0;
      #1 check($sformatf("hold_lvl_c%0d", c), rdata, model_read(2'd0));
      if (c == 5) check("hold_lvl_before", rdata, 32'h0);
      if (c == 6) check("hold_lvl_exact", rdata, 32'h1);
    end
    read_chk("hold_event", 1, 32'h1);
    read_chk("hold_count", 2, 32'h1);
    btn = '0;
    repeat (8) step();
    check_all("hold_release");

    // Bounce shorter than the debounce window is filtered out.
    bus_write(1, 32'h1f);
    bus_write(2, 32'h0);
    for (int c = 0; c < 40; c++) begin
      btn[0] = ((c / 2) % 2) == 1;
      step();
      addr = 32'h0;
      #1 check($sformatf("bounce_lvl_c%0d", c), rdata, model_read(2'd0));
    end
    btn = '0;
    repeat (4) step();
    read_chk("bounce_level", 0, 32'h0);
    read_chk("bounce_event", 1, 32'h0);
    read_chk("bounce_count", 2, 32'h0);

    // W1C and set-beats-clear.
    btn = 5'b00011;
    repeat (8) step();
    btn = '0;
    repeat (8) step();
    read_chk("w1c_pre", 1, 32'h3);
    bus_write(1, 32'h1);
    read_chk("w1c_bit0", 1, 32'h2);
    btn = 5'b00010;
    repeat (5) step();
    bus_write(1, 32'h2);          // lands on the edge of the new btn[1] press
    read_chk("set_wins", 1, 32'h2);
    check_all("set_wins_model");
    btn = '0;
    repeat (8) step();
    bus_write(1, 32'h2);
    read_chk("w1c_bit1", 1, 32'h0);

    // COUNT wrap from 0xFFFF with two simultaneous presses.
    force dut.count_q = 16'hFFFF;
    m_count = 16'hFFFF;
    #1 release dut.count_q;
    read_chk("cnt_preload", 2, 32'hFFFF);
    step();
    read_chk("cnt_hold_ffff", 2, 32'hFFFF);
    btn = 5'b00110;
    repeat (6) step();
    read_chk("cnt_wrap", 2, 32'h0001);
    check_all("cnt_wrap_model");
    btn = '0;
    repeat (8) step();

`ifdef BTN_IRQ_EN
    // Mask and interrupt timing.
    bus_write(1, 32'h1f);
    bus_write(3, 32'h4);
    read_chk("mask_rw", 3, 32'h4);
    btn = 5'b00100;
    for (int c = 1; c <= 7; c++) begin
      step();
      check($sformatf("irq_model_c%0d", c), {31'b0, irq}, {31'b0, m_irq});
      if (c == 6) begin
        read_chk("irq_evt_set", 1, 32'h4);
        check("irq_not_yet", {31'b0, irq}, 32'h0);
      end
      if (c == 7) check("irq_rise", {31'b0, irq}, 32'h1);
    end
    bus_write(1, 32'h4);
    check("irq_after_clr_edge", {31'b0, irq}, 32'h1);
    step();
    check("irq_fall", {31'b0, irq}, 32'h0);
    btn = '0;
    repeat (8) step();
`else
    // Without the interrupt feature MASK is inert and irq stays low.
    bus_write(3, 32'h1f);
    read_chk("mask_ro", 3, 32'h0);
    btn = 5'b00100;
    for (int c = 1; c <= 8; c++) begin
      step();
      check($sformatf("irq_low_c%0d", c), {31'b0, irq}, 32'h0);
    end
    btn = '0;
    repeat (8) step();
`endif

    // Reset mid-debounce, button still held through and after reset.
    btn = 5'b01000;
    repeat (3) step();
    rst = 1'b1;
    check_all("mid_rst_in");
    step();
    rst = 1'b0;
    for (int a = 0; a < 4; a++) read_chk($sformatf("mid_rst_reg%0d", a), a, 32'h0);
    for (int c = 1; c <= 6; c++) begin
      step();
      addr = 32'h4;
      if (c <= DEB + 1) #1 check($sformatf("no_evt_c%0d", c), rdata, 32'h0);
      else              #1 check("held_evt", rdata, 32'h8);
    end
    btn = '0;
    repeat (8) step();

    // Randomized traffic against the model.
    for (int it = 0; it < 600; it++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 5; i++)
        if ($urandom_range(0, 7) == 0) btn[i] = ~btn[i];
      we    = ($urandom_range(0, 9) == 0);
      addr  = $urandom;
      wdata = $urandom;
      #1 check($sformatf("rnd_rdata_%0d", it), rdata, model_read(addr[3:2]));
      check($sformatf("rnd_irq_%0d", it), {31'b0, irq}, {31'b0, m_irq});
      step();
    end
    we = 1'b0;
    rst = 1'b0;
    check_all("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button_event_resp.md
BUTTON_EVENT_RESP -- requirements
Module: button_event_resp

Interface
REQ-001 Parameter: DEB_CYCLES, default 20000; the number of consecutive cycles a synchronized input must hold a new value before the debounced level changes.
REQ-002 Port: clk, input, 1, CPU clock; all state updates on its rising edge.
REQ-003 Port: rst, input, 1, reset; synchronous, active-high.
REQ-004 Port: btn, input, 5, raw asynchronous push-button levels.
REQ-005 Port: addr, input, 32, bus address; only addr[3:2] is decoded.
REQ-006 Port: we, input, 1, bus write strobe; single-cycle write.
REQ-007 Port: wdata, input, 32, bus write data.
REQ-008 Port: rdata, output, 32, bus read data; combinational from addr.
REQ-009 Port: irq, output, 1, registered event interrupt request.

Function
REQ-010 Each btn bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Each button SHALL have a debounce counter, cleared whenever the synchronized value equals the debounced level.
REQ-012 When the synchronized value differs from the debounced level for DEB_CYCLES consecutive cycles, the debounced level SHALL toggle on that edge and the counter SHALL clear.
REQ-013 A 0->1 transition of the debounced level SHALL be a press event for one cycle.
REQ-014 The register map SHALL be selected by addr[3:2]:
- 0 LEVEL (RO): {27'b0, debounced[4:0]}
- 1 EVENT (W1C): {27'b0, flags[4:0]}
- 2 COUNT: {16'b0, cnt[15:0]}
- 3 MASK: {27'b0, mask[4:0]}
REQ-015 A press event on bit i SHALL set EVENT[i] on the next edge.
REQ-016 A write to EVENT SHALL clear each flag whose wdata bit is 1.
REQ-017 If a set and a clear hit the same flag in the same cycle, the set SHALL win.
REQ-018 COUNT SHALL increment by the number of simultaneous press events in a cycle (0..5), modulo 2^16; 0xFFFF+1 wraps to 0x0000.
REQ-019 Any write to COUNT SHALL reset it to the number of press events occurring in that same cycle.
REQ-020 Writes to LEVEL SHALL be ignored.
REQ-021 Writes SHALL take effect on the clock edge where we=1; rdata SHALL reflect the updated value from the following cycle.
REQ-022 Read latency SHALL be 0 cycles: rdata is combinational and must be stable within the same cycle for the bridge.

Reset
REQ-023 While rst=1 on a clock edge, all of the following SHALL be 0: synchronizers, debounce counters, debounced levels, EVENT, COUNT, MASK and irq.
REQ-024 rdata SHALL read 0 at every address during reset.
REQ-025 Reset asserted mid-debounce SHALL discard the partial count with no event generated.
REQ-026 Buttons held pressed through reset release SHALL produce a press event DEB_CYCLES+2 cycles after release of reset.

Configuration
REQ-027 The macro BTN_IRQ_EN SHALL enable the MASK register and interrupt generation.
REQ-028 With BTN_IRQ_EN defined:
- MASK is read/write.
- irq SHALL be registered as |(EVENT & MASK), with 1-cycle latency from the flag or mask change.
REQ-029 With BTN_IRQ_EN undefined:
- MASK reads 0 and writes are ignored.
- irq is constant 0.
- No mask or irq flops are synthesized.

Verification (DEB_CYCLES=4 for all scenarios)
REQ-030 Hold btn=5'b00001 high for 10 cycles -> LEVEL=0x1 exactly 6 cycles after the rise; EVENT=0x1; COUNT=1.
REQ-031 Toggle btn[0] every 2 cycles for 40 cycles -> LEVEL, EVENT and COUNT remain 0.
REQ-032 Set EVENT=0x3, then write 0x1 to EVENT -> reads 0x2; a write of 0x2 in the same cycle as a new btn[1] event -> EVENT keeps bit 1 set.
REQ-033 Preload COUNT=0xFFFF via 65535 presses (or force), press 2 buttons simultaneously -> COUNT=0x0001.
REQ-034 With BTN_IRQ_EN: MASK=0x4, press btn[2] -> irq=1 one cycle after EVENT[2] sets; clear EVENT[2] -> irq=0 next cycle. Without BTN_IRQ_EN: irq stays 0 and MASK reads 0.
REQ-035 Assert rst for 1 cycle while btn[3] is mid-debounce -> all registers read 0 and no event is produced within DEB_CYCLES+1 cycles after reset.
